// File: rtl/hazard_pkg.sv
// Shared types and defaults for the hazard/flush controller.
// Imported by the controller top.
package hazard_pkg;

  typedef enum logic {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_e;

  localparam logic [4:0] REG_ZERO = 5'd0;

  localparam int LOAD_STALL_CYCLES_DEF = 1;
  localparam int CNT_W_DEF             = 16;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter: counts inc_i cycles, holds at all-ones.
// Used for the stall and flush performance counters.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             inc_i,
  output logic [CNT_W-1:0] count_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (inc_i && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni)
      cnt_q <= '0;
    else
      cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/hazard_flush_ctrl.sv
// Load-use stall and branch/jump flush control for the 5-stage pipe.
// Outputs are combinational so the stall takes effect in the detect cycle.
module hazard_flush_ctrl
  import hazard_pkg::*;
#(
  parameter int LOAD_STALL_CYCLES = LOAD_STALL_CYCLES_DEF,
  parameter int CNT_W             = CNT_W_DEF
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             IDEX_MemRead_i,
  input  logic [4:0]       IDEX_RegisterRt_i,
  input  logic [4:0]       IFID_RegisterRs_i,
  input  logic [4:0]       IFID_RegisterRt_i,
  input  logic             IFID_UsesRt_i,
  input  logic             PCSrc_i,
  input  logic             Jump_i,
  output logic             PCWrite_o,
  output logic             IFID_Write_o,
  output logic             IF_Flush_o,
  output logic             ID_Flush_o,
  output logic             EX_Flush_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  localparam int RW = $clog2(LOAD_STALL_CYCLES) + 1;
  localparam logic [RW-1:0] RELOAD = RW'(LOAD_STALL_CYCLES - 1);
  localparam logic [RW-1:0] LAST   = RW'(1);

  state_e        state_q, state_d;
  logic [RW-1:0] remain_q, remain_d;

  logic hz;
  logic rs_hit;
  logic rt_hit;
  logic stall;
  logic br_flush;

  assign rs_hit = (IDEX_RegisterRt_i == IFID_RegisterRs_i);
  assign rt_hit = IFID_UsesRt_i &
                  (IDEX_RegisterRt_i == IFID_RegisterRt_i);

  assign hz = IDEX_MemRead_i &
              (IDEX_RegisterRt_i != REG_ZERO) &
              (rs_hit | rt_hit);

  // Reset forces the free-running defaults regardless of inputs.
  assign br_flush = rst_i & PCSrc_i;
  assign stall    = rst_i & ~PCSrc_i &
                    (hz | (state_q == STALL));

  always_comb begin
    PCWrite_o    = 1'b1;
    IFID_Write_o = 1'b1;
    IF_Flush_o   = 1'b0;
    ID_Flush_o   = 1'b0;
    EX_Flush_o   = 1'b0;
    if (br_flush) begin
      IF_Flush_o = 1'b1;
      ID_Flush_o = 1'b1;
      EX_Flush_o = 1'b1;
    end else if (stall) begin
      PCWrite_o    = 1'b0;
      IFID_Write_o = 1'b0;
      ID_Flush_o   = 1'b1;
    end else if (rst_i && Jump_i) begin
      IF_Flush_o = 1'b1;
    end
  end

  always_comb begin
    state_d  = state_q;
    remain_d = remain_q;
    if (PCSrc_i) begin
      state_d  = RUN;
      remain_d = '0;
    end else if (state_q == STALL) begin
      remain_d = remain_q - 1'b1;
      if (remain_q == LAST)
        state_d = RUN;
    end else if (hz && (LOAD_STALL_CYCLES > 1)) begin
      state_d  = STALL;
      remain_d = RELOAD;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= RUN;
      remain_q <= '0;
    end else begin
      state_q  <= state_d;
      remain_q <= remain_d;
    end
  end

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_stall_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .inc_i   (~PCWrite_o),
    .count_o (stall_cnt_o)
  );

  sat_counter #(
    .CNT_W (CNT_W)
  ) u_flush_cnt (
    .clk_i   (clk_i),
    .rst_ni  (rst_i),
    .inc_i   (br_flush),
    .count_o (flush_cnt_o)
  );

endmodule

// File: tb/tb_hazard_flush_ctrl.sv
// Bench for hazard_flush_ctrl: three configurations share one stimulus
// stream and are checked against a cycle-count reference model.
module tb_hazard_flush_ctrl;

  typedef struct {
    logic       memrd;
    logic [4:0] exrt;
    logic [4:0] idrs;
    logic [4:0] idrt;
    logic       usesrt;
    logic       pcsrc;
    logic       jump;
  } vin_t;

  typedef struct {
    vin_t       v;
    logic [4:0] exp;
  } tv_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       memrd = 1'b0;
  logic [4:0] exrt = '0;
  logic [4:0] idrs = '0;
  logic [4:0] idrt = '0;
  logic       usesrt = 1'b0;
  logic       pcsrc = 1'b0;
  logic       jump = 1'b0;

  logic [4:0]  o [3];
  logic [15:0] sc [3];
  logic [15:0] fc [3];
  logic [1:0]  sc_c, fc_c;

  assign sc[2] = {14'b0, sc_c};
  assign fc[2] = {14'b0, fc_c};

  always #5 clk = ~clk;

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(1), .CNT_W(16)) dA (
    .clk_i(clk), .rst_i(rst_n),
    .IDEX_MemRead_i(memrd), .IDEX_RegisterRt_i(exrt),
    .IFID_RegisterRs_i(idrs), .IFID_RegisterRt_i(idrt),
    .IFID_UsesRt_i(usesrt), .PCSrc_i(pcsrc), .Jump_i(jump),
    .PCWrite_o(o[0][4]), .IFID_Write_o(o[0][3]),
    .IF_Flush_o(o[0][2]), .ID_Flush_o(o[0][1]), .EX_Flush_o(o[0][0]),
    .stall_cnt_o(sc[0]), .flush_cnt_o(fc[0])
  );

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(16)) dB (
    .clk_i(clk), .rst_i(rst_n),
    .IDEX_MemRead_i(memrd), .IDEX_RegisterRt_i(exrt),
    .IFID_RegisterRs_i(idrs), .IFID_RegisterRt_i(idrt),
    .IFID_UsesRt_i(usesrt), .PCSrc_i(pcsrc), .Jump_i(jump),
    .PCWrite_o(o[1][4]), .IFID_Write_o(o[1][3]),
    .IF_Flush_o(o[1][2]), .ID_Flush_o(o[1][1]), .EX_Flush_o(o[1][0]),
    .stall_cnt_o(sc[1]), .flush_cnt_o(fc[1])
  );

  hazard_flush_ctrl #(.LOAD_STALL_CYCLES(3), .CNT_W(2)) dC (
    .clk_i(clk), .rst_i(rst_n),
    .IDEX_MemRead_i(memrd), .IDEX_RegisterRt_i(exrt),
    .IFID_RegisterRs_i(idrs), .IFID_RegisterRt_i(idrt),
    .IFID_UsesRt_i(usesrt), .PCSrc_i(pcsrc), .Jump_i(jump),
    .PCWrite_o(o[2][4]), .IFID_Write_o(o[2][3]),
    .IF_Flush_o(o[2][2]), .ID_Flush_o(o[2][1]), .EX_Flush_o(o[2][0]),
    .stall_cnt_o(sc_c), .flush_cnt_o(fc_c)
  );

  int lsc  [3] = '{1, 3, 3};
  int maxc [3] = '{65535, 65535, 3};
  int left [3];
  int scnt [3];
  int fcnt [3];

  int passed = 0;
  int total  = 0;

  task automatic chk(input string nm, input int k, input int got,
                     input int exp);
    total++;
    if (got == exp) passed++;
    else $display("FAIL %s dut%0d t=%0t got %0d exp %0d",
                  nm, k, $time, got, exp);
  endtask

  function automatic bit hz_f();
    return memrd && (exrt != 0) &&
           ((exrt == idrs) || (usesrt && (exrt == idrt)));
  endfunction

  // Expected {PCWrite, IFID_Write, IF_Flush, ID_Flush, EX_Flush}.
  function automatic logic [4:0] mexp(input int k);
    if (!rst_n)                    return 5'b11000;
    if (pcsrc)                     return 5'b11111;
    if ((left[k] > 0) || hz_f())   return 5'b00010;
    if (jump)                      return 5'b11100;
    return 5'b11000;
  endfunction

  task automatic step(input vin_t v, input logic r,
                      input bit useA, input logic [4:0] expA);
    logic [4:0] e [3];
    @(negedge clk);
    memrd = v.memrd; exrt = v.exrt; idrs = v.idrs; idrt = v.idrt;
    usesrt = v.usesrt; pcsrc = v.pcsrc; jump = v.jump;
    rst_n = r;
    if (!r)
      for (int k = 0; k < 3; k++) begin
        left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
      end
    #1;
    if (useA) chk("table", 0, int'(o[0]), int'(expA));
    for (int k = 0; k < 3; k++) begin
      e[k] = mexp(k);
      chk("outs", k, int'(o[k]), int'(e[k]));
      chk("stall_cnt", k, int'(sc[k]), scnt[k]);
      chk("flush_cnt", k, int'(fc[k]), fcnt[k]);
    end
    @(posedge clk);
    if (r)
      for (int k = 0; k < 3; k++) begin
        if (!e[k][4] && scnt[k] < maxc[k]) scnt[k]++;
        if (pcsrc && fcnt[k] < maxc[k]) fcnt[k]++;
        if (pcsrc)             left[k] = 0;
        else if (left[k] > 0)  left[k]--;
        else if (hz_f())       left[k] = lsc[k] - 1;
      end
  endtask

  vin_t IDLE, LU, PC, JMP, rv;
  tv_t  tbl [10];

  task automatic do_reset();
    step(IDLE, 1'b0, 1'b0, 5'b0);
    step(IDLE, 1'b0, 1'b0, 5'b0);
  endtask

  initial begin
    IDLE = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0};
    LU   = '{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b0};
    PC   = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0};
    JMP  = '{1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1};

    tbl[0] = '{IDLE, 5'b11000};
    tbl[1] = '{LU, 5'b00010};
    tbl[2] = '{'{1'b1, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0}, 5'b11000};
    tbl[3] = '{'{1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0}, 5'b11000};
    tbl[4] = '{'{1'b1, 5'd9, 5'd3, 5'd9, 1'b1, 1'b0, 1'b0}, 5'b00010};
    tbl[5] = '{'{1'b0, 5'd8, 5'd8, 5'd8, 1'b1, 1'b0, 1'b0}, 5'b11000};
    tbl[6] = '{JMP, 5'b11100};
    tbl[7] = '{'{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b0, 1'b1}, 5'b00010};
    tbl[8] = '{'{1'b1, 5'd8, 5'd8, 5'd0, 1'b0, 1'b1, 1'b1}, 5'b11111};
    tbl[9] = '{PC, 5'b11111};

    for (int k = 0; k < 3; k++) begin
      left[k] = 0; scnt[k] = 0; fcnt[k] = 0;
    end

    do_reset();
    for (int i = 0; i < 10; i++)
      step(tbl[i].v, 1'b1, 1'b1, tbl[i].exp);

    // Reset dropped in the second stall cycle of the 3-cycle config.
    do_reset();
    step(LU, 1'b1, 1'b0, 5'b0);
    step(IDLE, 1'b0, 1'b0, 5'b0);
    #1;
    chk("rst_outs", 1, int'(o[1]), int'(5'b11000));
    chk("rst_scnt", 1, int'(sc[1]), 0);
    step(IDLE, 1'b1, 1'b0, 5'b0);
    #1;
    chk("rst_run", 1, int'(o[1]), int'(5'b11000));

    // Single-cycle load-use stall.
    do_reset();
    step(LU, 1'b1, 1'b0, 5'b0);
    step(IDLE, 1'b1, 1'b0, 5'b0);
    #1;
    chk("lu1_scnt", 0, int'(sc[0]), 1);
    chk("lu1_outs", 0, int'(o[0]), int'(5'b11000));

    // One-cycle hazard pulse held for three cycles.
    do_reset();
    step(LU, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 3; i++) step(IDLE, 1'b1, 1'b0, 5'b0);
    #1;
    chk("lu3_scnt", 1, int'(sc[1]), 3);
    chk("lu3_outs", 1, int'(o[1]), int'(5'b11000));

    // Branch flush aborts a stall in its second cycle.
    do_reset();
    step(LU, 1'b1, 1'b0, 5'b0);
    step(PC, 1'b1, 1'b0, 5'b0);
    #1;
    chk("abort_fcnt", 1, int'(fc[1]), 1);
    step(IDLE, 1'b1, 1'b0, 5'b0);
    #1;
    chk("abort_run", 1, int'(o[1]), int'(5'b11000));
    chk("abort_scnt", 1, int'(sc[1]), 1);

    // Jump held during a stall, then flush counter saturation.
    do_reset();
    step(LU, 1'b1, 1'b0, 5'b0);
    step(JMP, 1'b1, 1'b0, 5'b0);
    step(JMP, 1'b1, 1'b0, 5'b0);
    step(JMP, 1'b1, 1'b0, 5'b0);
    for (int i = 0; i < 5; i++) step(PC, 1'b1, 1'b0, 5'b0);
    #1;
    chk("sat_fcnt", 2, int'(fc[2]), 3);
    chk("nosat_fcnt", 0, int'(fc[0]), 5);

    // Randomized traffic.
    do_reset();
    for (int i = 0; i < 400; i++) begin
      rv.memrd  = ($urandom_range(0, 1) == 1);
      rv.exrt   = 5'($urandom_range(0, 3));
      rv.idrs   = 5'($urandom_range(0, 3));
      rv.idrt   = 5'($urandom_range(0, 3));
      rv.usesrt = ($urandom_range(0, 1) == 1);
      rv.pcsrc  = ($urandom_range(0, 9) == 0);
      rv.jump   = ($urandom_range(0, 4) == 0);
      step(rv, ($urandom_range(0, 99) != 0), 1'b0, 5'b0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
